// File: rtl/pcie_tx_sched.sv
// Transmit-side scheduler: arbitrates the lane symbol stream between TLP, DLLP and SKP
// ordered sets, and paces SKP insertion from an Enable-qualified interval counter.
module pcie_tx_sched #(
  parameter int unsigned SkpInterval  = 1180,
  parameter int unsigned SkpLen       = 4,
  parameter int unsigned SkpPendMax   = 3,
  parameter int unsigned DllpBurstMax = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       TlpReq,
  input  logic       TlpLast,
  output logic       TlpGnt,
  input  logic       DllpReq,
  input  logic       DllpLast,
  output logic       DllpGnt,
  output logic       SkpGnt,
  output logic [1:0] Sel,
  output logic [2:0] SkpPending,
  output logic       SkpOverflow,
  output logic       ProtoErr
);

  localparam int unsigned IvlW   = $clog2(SkpInterval);
  localparam int unsigned SkpW   = (SkpLen > 1) ? $clog2(SkpLen) : 1;
  localparam int unsigned BurstW = (DllpBurstMax > 0) ? $clog2(DllpBurstMax + 1) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StTlp  = 2'd1,
    StDllp = 2'd2,
    StSkp  = 2'd3
  } state_e;

  state_e            r_state, w_state_d;
  logic [IvlW-1:0]   r_ivl, w_ivl_d;
  logic [2:0]        r_pend, w_pend_d;
  logic [SkpW-1:0]   r_skp_cnt, w_skp_cnt_d;
  logic [BurstW-1:0] r_burst, w_burst_d;
  logic              r_ovf, w_ovf_d;
  logic              r_perr, w_perr_d;
  logic              w_ivl_evt, w_skp_entry, w_skp_final, w_arb;

  always_comb begin
    w_ivl_evt   = Enable && (r_ivl == IvlW'(SkpInterval - 1));
    w_skp_entry = (r_state == StSkp) && (r_skp_cnt == '0);
    w_skp_final = (r_state == StSkp) && (r_skp_cnt == SkpW'(SkpLen - 1));

    w_ivl_d = r_ivl;
    if (Enable) begin
      w_ivl_d = w_ivl_evt ? '0 : r_ivl + 1'b1;
    end

    // An event coinciding with the SKP entry decrement cancels out.
    w_pend_d = r_pend;
    w_ovf_d  = r_ovf;
    if (w_ivl_evt && !w_skp_entry) begin
      if (r_pend == 3'(SkpPendMax)) begin
        w_ovf_d = 1'b1;
      end else begin
        w_pend_d = r_pend + 3'd1;
      end
    end else if (!w_ivl_evt && w_skp_entry && (r_pend != '0)) begin
      w_pend_d = r_pend - 3'd1;
    end

    w_state_d = r_state;
    w_burst_d = r_burst;
    w_perr_d  = r_perr;
    w_arb     = 1'b0;
    unique case (r_state)
      StIdle: w_arb = 1'b1;
      StTlp: begin
        if (TlpLast) begin
          w_arb = 1'b1;
        end else if (!TlpReq) begin
          w_perr_d  = 1'b1;
          w_state_d = StIdle;
        end
      end
      StDllp: begin
        if (DllpLast) begin
          w_arb = 1'b1;
        end else if (!DllpReq) begin
          w_perr_d  = 1'b1;
          w_state_d = StIdle;
        end
      end
      StSkp:   w_arb = w_skp_final;
      default: w_arb = 1'b1;
    endcase

    // Arbitration sees this cycle's interval event via the next pending count.
    if (w_arb) begin
      if (!Enable) begin
        w_state_d = StIdle;
      end else if (w_pend_d != '0) begin
        w_state_d = StSkp;
      end else if (DllpReq && TlpReq && (r_burst == BurstW'(DllpBurstMax))) begin
        w_state_d = StTlp;
        w_burst_d = '0;
      end else if (DllpReq) begin
        w_state_d = StDllp;
        w_burst_d = TlpReq ? r_burst + 1'b1 : '0;
      end else if (TlpReq) begin
        w_state_d = StTlp;
        w_burst_d = '0;
      end else begin
        w_state_d = StIdle;
      end
    end

    w_skp_cnt_d = ((r_state == StSkp) && !w_skp_final) ? r_skp_cnt + 1'b1 : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= StIdle;
      r_ivl     <= '0;
      r_pend    <= '0;
      r_skp_cnt <= '0;
      r_burst   <= '0;
      r_ovf     <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_ivl     <= w_ivl_d;
      r_pend    <= w_pend_d;
      r_skp_cnt <= w_skp_cnt_d;
      r_burst   <= w_burst_d;
      r_ovf     <= w_ovf_d;
      r_perr    <= w_perr_d;
    end
  end

  assign Sel         = r_state;
  assign TlpGnt      = (r_state == StTlp);
  assign DllpGnt     = (r_state == StDllp);
  assign SkpGnt      = (r_state == StSkp);
  assign SkpPending  = r_pend;
  assign SkpOverflow = r_ovf;
  assign ProtoErr    = r_perr;

endmodule

// File: tb/tb_pcie_tx_sched.sv
// Bench for pcie_tx_sched: per-cycle comparison against a behavioural model plus
// directed scenarios with hand-computed expectations.
module tb_pcie_tx_sched;
  localparam int SkpInterval  = 1180;
  localparam int SkpLen       = 4;
  localparam int SkpPendMax   = 3;
  localparam int DllpBurstMax = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0, Enable = 1'b0;
  logic       TlpReq = 1'b0, TlpLast = 1'b0, DllpReq = 1'b0, DllpLast = 1'b0;
  logic       TlpGnt, DllpGnt, SkpGnt, SkpOverflow, ProtoErr;
  logic [1:0] Sel;
  logic [2:0] SkpPending;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  pcie_tx_sched #(
    .SkpInterval (SkpInterval),
    .SkpLen      (SkpLen),
    .SkpPendMax  (SkpPendMax),
    .DllpBurstMax(DllpBurstMax)
  ) u_dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Enable     (Enable),
    .TlpReq     (TlpReq),
    .TlpLast    (TlpLast),
    .TlpGnt     (TlpGnt),
    .DllpReq    (DllpReq),
    .DllpLast   (DllpLast),
    .DllpGnt    (DllpGnt),
    .SkpGnt     (SkpGnt),
    .Sel        (Sel),
    .SkpPending (SkpPending),
    .SkpOverflow(SkpOverflow),
    .ProtoErr   (ProtoErr)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: owner 0 idle, 1 TLP, 2 DLLP, 3 SKP; skp_left counts cycles remaining.
  int m_owner = 0, m_ivl = 0, m_pend = 0, m_streak = 0, m_skp_left = 0;
  bit m_ovf = 1'b0, m_perr = 1'b0;

  initial begin
    int  nown, npend, nskp;
    bit  evt, entry, boundary;
    forever begin
      @(posedge Clk);
      if (Reset) begin
        m_owner = 0; m_ivl = 0; m_pend = 0; m_streak = 0; m_skp_left = 0;
        m_ovf = 1'b0; m_perr = 1'b0;
      end else begin
        evt = Enable && (m_ivl == SkpInterval - 1);
        if (Enable) m_ivl = evt ? 0 : m_ivl + 1;
        entry = (m_owner == 3) && (m_skp_left == SkpLen);
        npend = m_pend + (evt ? 1 : 0) - (entry ? 1 : 0);
        if (npend > SkpPendMax) begin
          npend = SkpPendMax;
          m_ovf = 1'b1;
        end
        boundary = 1'b0;
        nown = m_owner;
        nskp = (m_owner == 3) ? m_skp_left - 1 : 0;
        case (m_owner)
          0: boundary = 1'b1;
          1: if (TlpLast) boundary = 1'b1;
             else if (!TlpReq) begin m_perr = 1'b1; nown = 0; end
          2: if (DllpLast) boundary = 1'b1;
             else if (!DllpReq) begin m_perr = 1'b1; nown = 0; end
          default: boundary = (m_skp_left == 1);
        endcase
        if (boundary) begin
          if (!Enable) nown = 0;
          else if (npend > 0) begin nown = 3; nskp = SkpLen; end
          else if (DllpReq && TlpReq && m_streak >= DllpBurstMax) begin nown = 1; m_streak = 0; end
          else if (DllpReq) begin nown = 2; m_streak = TlpReq ? m_streak + 1 : 0; end
          else if (TlpReq) begin nown = 1; m_streak = 0; end
          else nown = 0;
        end
        m_owner = nown; m_pend = npend; m_skp_left = nskp;
      end
    end
  end

  initial begin
    logic [9:0] e, a;
    forever begin
      @(negedge Clk);
      if (chk_en) begin
        e = {2'(m_owner), m_owner == 1, m_owner == 2, m_owner == 3, 3'(m_pend), m_ovf, m_perr};
        a = {Sel, TlpGnt, DllpGnt, SkpGnt, SkpPending, SkpOverflow, ProtoErr};
        checks++;
        if (a !== e) begin
          errors++;
          if (errors <= 20) $display("FAIL model t=%0t: actual %b required %b", $time, a, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset(input bit en);
    @(negedge Clk);
    Reset = 1'b1; Enable = 1'b0;
    TlpReq = 1'b0; TlpLast = 1'b0; DllpReq = 1'b0; DllpLast = 1'b0;
    tick(2);
    chk_en = 1'b1;
    Reset = 1'b0; Enable = en;
  endtask

  // Sends one packet of n groups; returns on the negedge of the last granted group.
  task automatic send(input bit dllp, input int n);
    int k = 0;
    int waited = 0;
    if (dllp) begin DllpReq = 1'b1; DllpLast = 1'b0; end
    else begin TlpReq = 1'b1; TlpLast = 1'b0; end
    while (k < n) begin
      @(negedge Clk);
      if (dllp ? DllpGnt : TlpGnt) begin
        k++;
        if (k == n) begin
          if (dllp) begin DllpLast = 1'b1; DllpReq = 1'b0; end
          else begin TlpLast = 1'b1; TlpReq = 1'b0; end
        end
      end else if (++waited > 20000) begin
        checks++; errors++;
        $display("FAIL send timeout: actual %0d groups required %0d", k, n);
        k = n;
      end
    end
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcnt, first, last, scnt;

    // SKP pacing from idle
    do_reset(1'b1);
    chk("reset outputs", 32'({Sel, TlpGnt, DllpGnt, SkpGnt, SkpPending, SkpOverflow, ProtoErr}), 0);
    tick(1179);
    chk("pend before event", 32'(SkpPending), 0);
    chk("idle before event", 32'(Sel), 0);
    tick(1);
    chk("pend after event", 32'(SkpPending), 1);
    chk("skp first cycle", 32'(Sel), 3);
    tick(1);
    chk("pend after entry", 32'(SkpPending), 0);
    chk("skp gnt second", 32'(SkpGnt), 1);
    tick(2);
    chk("skp fourth cycle", 32'(Sel), 3);
    tick(1);
    chk("idle after skp", 32'(Sel), 0);

    // Single 6-group TLP
    do_reset(1'b1);
    chk("no tlp gnt before req", 32'(TlpGnt), 0);
    TlpReq = 1'b1;
    gcnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (TlpGnt === 1'b1) gcnt++;
      if (i == 1) chk("tlp grant latency", 32'(TlpGnt), 1);
      if (i == 6) begin TlpLast = 1'b1; TlpReq = 1'b0; end
    end
    chk("tlp group count", 32'(gcnt), 6);
    chk("idle after tlp", 32'(Sel), 0);
    TlpLast = 1'b0;

    // DLLP burst limit with both sources continuously requesting
    do_reset(1'b1);
    TlpReq = 1'b1; DllpReq = 1'b1; TlpLast = 1'b1; DllpLast = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      chk($sformatf("burst seq %0d", i), 32'(Sel), (i % 3 == 2) ? 1 : 2);
    end
    TlpReq = 1'b0; DllpReq = 1'b0;

    // Interval event during group 3 of a 10-group TLP
    do_reset(1'b1);
    tick(1176);
    send(1'b0, 10);
    chk("pend during tlp", 32'(SkpPending), 1);
    chk("tlp last group", 32'(Sel), 1);
    tick(1);
    chk("skp after tlp", 32'(Sel), 3);
    tick(1);
    chk("pend after deferred skp", 32'(SkpPending), 0);
    TlpLast = 1'b0;
    tick(4);

    // Saturation while a long TLP blocks SKP, then three back-to-back SKPs
    do_reset(1'b0);
    tick(5 * SkpInterval);
    chk("pend frozen disabled", 32'(SkpPending), 0);
    Enable = 1'b1;
    send(1'b0, 4 * SkpInterval + 1);
    chk("pend saturated", 32'(SkpPending), 3);
    chk("overflow set", 32'(SkpOverflow), 1);
    first = -1; last = -1; scnt = 0;
    for (int i = 1; i <= 14; i++) begin
      tick(1);
      if (Sel === 2'd3) begin
        scnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("skp cycles", 32'(scnt), 12);
    chk("skp start", 32'(first), 1);
    chk("skp contiguous", 32'(last - first), 11);
    chk("pend drained", 32'(SkpPending), 0);
    chk("overflow sticky", 32'(SkpOverflow), 1);
    TlpLast = 1'b0;

    // Protocol error: TLP request dropped at group 2
    do_reset(1'b1);
    TlpReq = 1'b1;
    tick(2);
    chk("tlp group2", 32'(TlpGnt), 1);
    TlpReq = 1'b0;
    tick(1);
    chk("proto err", 32'(ProtoErr), 1);
    chk("idle after proto", 32'(Sel), 0);
    send(1'b1, 1);
    chk("dllp after err", 32'(DllpGnt), 1);
    tick(1);
    chk("idle after dllp", 32'(Sel), 0);
    chk("proto err sticky", 32'(ProtoErr), 1);
    DllpLast = 1'b0;
    do_reset(1'b1);
    chk("reset clears proto", 32'(ProtoErr), 0);

    // Enable drop mid-packet: packet completes, new grants blocked
    TlpReq = 1'b1;
    tick(1);
    Enable = 1'b0;
    DllpReq = 1'b1;
    tick(2);
    chk("tlp holds disabled", 32'(TlpGnt), 1);
    TlpLast = 1'b1; TlpReq = 1'b0;
    tick(1);
    chk("idle when disabled", 32'(Sel), 0);
    TlpLast = 1'b0;
    tick(2);
    chk("still idle disabled", 32'(Sel), 0);
    Enable = 1'b1;
    tick(1);
    chk("dllp after enable", 32'(DllpGnt), 1);
    DllpLast = 1'b1; DllpReq = 1'b0;
    tick(2);
    DllpLast = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
